// File: rtl/metronome_pkg.sv
// Purpose: shared encodings and default tempo bounds for the metronome blocks.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package metronome_pkg;

    // Which tempo button is acting this cycle; NONE when all are released.
    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_P1   = 3'd1,
        SEL_P5   = 3'd2,
        SEL_M1   = 3'd3,
        SEL_M5   = 3'd4
    } btn_sel_t;

    // Step controller FSM: first step in IDLE, initial delay in HOLD,
    // periodic stepping in REPEAT.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } step_state_t;

    // Tempo bounds shared with the beat-period generator.
    localparam int DEF_BPM_MIN  = 30;
    localparam int DEF_BPM_MAX  = 300;
    localparam int DEF_BPM_INIT = 120;

    // Fixed priority: plus_1 > plus_5 > minus_1 > minus_5.
    function automatic btn_sel_t pick_button(input logic p1, input logic p5,
                                             input logic m1, input logic m5);
        if (p1)      return SEL_P1;
        else if (p5) return SEL_P5;
        else if (m1) return SEL_M1;
        else if (m5) return SEL_M5;
        else         return SEL_NONE;
    endfunction

endpackage

// File: rtl/bpm_clamp_add.sv
// Purpose: signed add of a step delta to a BPM value, clamped to [BPM_MIN, BPM_MAX].
// Latency: purely combinational.
// Backpressure: none.
// Ports: bpm_i current tempo, delta_i signed step (BPM_W+2 bits),
//        bpm_o clamped result, changed_o high when bpm_o differs from bpm_i.
module bpm_clamp_add #(
    parameter int BPM_W   = 9,
    parameter int BPM_MIN = 30,
    parameter int BPM_MAX = 300
) (
    input  logic [BPM_W-1:0]        bpm_i,
    input  logic signed [BPM_W+1:0] delta_i,
    output logic [BPM_W-1:0]        bpm_o,
    output logic                    changed_o
);

    localparam int SW = BPM_W + 2;
    // Bounds as signed constants so the comparisons below stay signed.
    localparam logic signed [SW-1:0] MIN_S = SW'(BPM_MIN);
    localparam logic signed [SW-1:0] MAX_S = SW'(BPM_MAX);

    logic signed [SW-1:0] sum_s;

    always_comb begin
        // Two guard bits: one for the sign, one so BPM + step cannot overflow.
        sum_s = $signed({2'b00, bpm_i}) + delta_i;
        if (sum_s < MIN_S) begin
            bpm_o = BPM_W'(BPM_MIN);
        end else if (sum_s > MAX_S) begin
            bpm_o = BPM_W'(BPM_MAX);
        end else begin
            bpm_o = sum_s[BPM_W-1:0];
        end
        changed_o = (bpm_o != bpm_i);
    end

endmodule

// File: rtl/bpm_step_controller.sv
// Purpose: tempo register driven by four level buttons with saturating steps and hold-to-repeat.
// Latency: one i_clk edge from the first sampled button level to the new o_bpm.
// Backpressure: none; buttons are sampled every cycle and o_bpm_changed is a bare pulse.
// Ports: i_clk, i_reset (async, active-high), i_btn_plus_1/plus_5/minus_1/minus_5 (levels),
//        o_bpm tempo, o_bpm_changed change strobe, o_at_min/o_at_max bound flags,
//        o_repeating high while in auto-repeat.
module bpm_step_controller
    import metronome_pkg::*;
#(
    parameter int BPM_W         = 9,
    parameter int BPM_MIN       = DEF_BPM_MIN,
    parameter int BPM_MAX       = DEF_BPM_MAX,
    parameter int BPM_INIT      = DEF_BPM_INIT,
    parameter int STEP_SMALL    = 1,
    parameter int STEP_LARGE    = 5,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_btn_plus_1,
    input  logic             i_btn_plus_5,
    input  logic             i_btn_minus_1,
    input  logic             i_btn_minus_5,
    output logic [BPM_W-1:0] o_bpm,
    output logic             o_bpm_changed,
    output logic             o_at_min,
    output logic             o_at_max,
    output logic             o_repeating
);

    localparam int DW      = BPM_W + 2;
    localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] HOLD_RELOAD   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_RELOAD = TMR_W'(REPEAT_CYCLES - 1);
    localparam logic [BPM_W-1:0] INIT_V        = BPM_W'(BPM_INIT);
    localparam logic [BPM_W-1:0] MIN_V         = BPM_W'(BPM_MIN);
    localparam logic [BPM_W-1:0] MAX_V         = BPM_W'(BPM_MAX);

    btn_sel_t            sel;
    logic signed [DW-1:0] delta;
    logic [BPM_W-1:0]    step_bpm;
    logic                step_changed;

    step_state_t         state_q, state_d;
    btn_sel_t            act_q, act_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                step_en;
    logic [BPM_W-1:0]    bpm_q, bpm_d;
    logic                changed_q, at_min_q, at_max_q, repeating_q;

    always_comb begin
        sel = pick_button(i_btn_plus_1, i_btn_plus_5, i_btn_minus_1, i_btn_minus_5);
        case (sel)
            SEL_P1:  delta = DW'(STEP_SMALL);
            SEL_P5:  delta = DW'(STEP_LARGE);
            SEL_M1:  delta = -DW'(STEP_SMALL);
            SEL_M5:  delta = -DW'(STEP_LARGE);
            default: delta = '0;
        endcase
    end

    bpm_clamp_add #(
        .BPM_W   (BPM_W),
        .BPM_MIN (BPM_MIN),
        .BPM_MAX (BPM_MAX)
    ) u_clamp (
        .bpm_i     (bpm_q),
        .delta_i   (delta),
        .bpm_o     (step_bpm),
        .changed_o (step_changed)
    );

    // Next-state logic. A press of a different button while holding restarts
    // the whole sequence in the same edge, so the new button steps at once.
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        timer_d = timer_q;
        step_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel != SEL_NONE) begin
                    step_en = 1'b1;
                    act_d   = sel;
                    timer_d = HOLD_RELOAD;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (sel == SEL_NONE) begin
                    state_d = ST_IDLE;
                    act_d   = SEL_NONE;
                    timer_d = '0;
                end else if (sel != act_q) begin
                    step_en = 1'b1;
                    act_d   = sel;
                    timer_d = HOLD_RELOAD;
                    state_d = ST_HOLD;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TMR_W'(1);
                end else begin
                    // Timer is always reloaded here, so it never wraps.
                    step_en = 1'b1;
                    timer_d = REPEAT_RELOAD;
                    state_d = ST_REPEAT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                act_d   = SEL_NONE;
                timer_d = '0;
            end
        endcase
        bpm_d = step_en ? step_bpm : bpm_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            act_q       <= SEL_NONE;
            timer_q     <= '0;
            bpm_q       <= INIT_V;
            changed_q   <= 1'b0;
            at_min_q    <= (INIT_V == MIN_V);
            at_max_q    <= (INIT_V == MAX_V);
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            timer_q     <= timer_d;
            bpm_q       <= bpm_d;
            // Stepping into a bound we already sit on is not a change.
            changed_q   <= step_en & step_changed;
            at_min_q    <= (bpm_d == MIN_V);
            at_max_q    <= (bpm_d == MAX_V);
            repeating_q <= (state_d == ST_REPEAT);
        end
    end

    assign o_bpm         = bpm_q;
    assign o_bpm_changed = changed_q;
    assign o_at_min      = at_min_q;
    assign o_at_max      = at_max_q;
    assign o_repeating   = repeating_q;

endmodule
